// File: rtl/uart_word_transmit.sv
// 8N1 UART transmitter for a WORD_WIDTH word, least-significant byte first, with no idle gap between bytes.
// Line goes low the cycle after accept; ready reopens in the last stop-bit cycle, so words can run back-to-back.
module uart_word_transmit #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int WORD_WIDTH       = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid_in,
    output logic                  word_ready_out,
    output logic                  busy_out,
    output logic                  byte_done_out,
    output logic                  word_done_out,
    output logic                  tx_wire_out
);

    localparam int CPB    = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int BYTES  = WORD_WIDTH / 8;
    localparam int BAUD_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CPB - 1);
    localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CPB - 2);
    localparam logic [BYTE_W-1:0] BYTE_LAST   = BYTE_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    logic [BAUD_W-1:0]     r_baud_cnt;
    logic [2:0]            r_bit_idx;
    logic [BYTE_W-1:0]     r_byte_idx;
    logic [WORD_WIDTH-1:0] r_shift;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_ready;
    logic                  r_byte_done;
    logic                  r_word_done;

    logic w_accept;
    logic w_baud_end;
    logic w_stop_penult;
    logic w_last_byte;

    assign w_accept      = word_valid_in & r_ready;
    assign w_baud_end    = (r_baud_cnt == BAUD_LAST);
    assign w_stop_penult = (r_state == S_STOP) && (r_baud_cnt == BAUD_PENULT);
    assign w_last_byte   = (r_byte_idx == BYTE_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_byte_idx  <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_byte_done <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_word_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_baud_cnt <= '0;
                    r_bit_idx  <= '0;
                    if (w_accept) begin
                        r_shift    <= word_in;
                        r_byte_idx <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ready    <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        // Shifting once per bit leaves the next byte in the low lane after bit 7.
                        r_baud_cnt <= '0;
                        r_shift    <= r_shift >> 1;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Strobes are set one cycle early so they coincide with the final stop cycle.
                    if (w_stop_penult) begin
                        r_byte_done <= 1'b1;
                        r_word_done <= w_last_byte;
                        r_ready     <= w_last_byte;
                    end
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        if (!w_last_byte) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end else if (w_accept) begin
                            r_shift    <= word_in;
                            r_byte_idx <= '0;
                            r_tx       <= 1'b0;
                            r_ready    <= 1'b0;
                            r_state    <= S_START;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign word_ready_out = r_ready;
    assign busy_out       = r_busy;
    assign byte_done_out  = r_byte_done;
    assign word_done_out  = r_word_done;
    assign tx_wire_out    = r_tx;

endmodule

// File: tb/tb_uart_word_transmit.sv
// Randomized bench for uart_word_transmit: expected bytes are queued on issue, a line monitor decodes and compares.
module tb_uart_word_transmit;

    localparam int CPB      = 4;
    localparam int BYTE_CYC = 10 * CPB;

    logic        clk_in;
    logic        rst_in;
    logic [15:0] word_in;
    logic        word_valid_in;
    logic        word_ready_out;
    logic        busy_out;
    logic        byte_done_out;
    logic        word_done_out;
    logic        tx_wire_out;

    uart_word_transmit #(
        .INPUT_CLOCK_FREQ(40),
        .BAUD_RATE       (10),
        .WORD_WIDTH      (16)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .word_in       (word_in),
        .word_valid_in (word_valid_in),
        .word_ready_out(word_ready_out),
        .busy_out      (busy_out),
        .byte_done_out (byte_done_out),
        .word_done_out (word_done_out),
        .tx_wire_out   (tx_wire_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [7:0] data;
        bit         last;
        bit         contig;
    } exp_byte_t;

    exp_byte_t exp_q[$];
    exp_byte_t cur;
    int        n_checks = 0;
    int        n_pass   = 0;
    int        cyc      = 0;
    int        prev_end = -100;
    int        mon_cnt  = 0;
    bit        mon_active = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: a word is 2 bytes LSB first; byte = start(0), 8 data bits LSB first, stop(1), CPB cycles each.
    task automatic push_word(input logic [15:0] w, input bit contig_first);
        exp_byte_t b;
        b.data = w[7:0];  b.last = 1'b0; b.contig = contig_first; exp_q.push_back(b);
        b.data = w[15:8]; b.last = 1'b1; b.contig = 1'b1;         exp_q.push_back(b);
    endtask

    always @(negedge clk_in) begin
        logic [7:0] d;
        logic       exp_tx;
        int         slot;
        cyc++;
        if (rst_in) begin
            mon_active = 1'b0;
            mon_cnt    = 0;
        end else begin
            if (!mon_active && tx_wire_out === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    if (cur.contig) chk("no_gap_start", cyc, prev_end + 1);
                end
            end
            if (mon_active) begin
                d    = cur.data;
                slot = mon_cnt / CPB;
                if (slot == 0)      exp_tx = 1'b0;
                else if (slot == 9) exp_tx = 1'b1;
                else                exp_tx = d[slot-1];
                chk("tx_bit", tx_wire_out, exp_tx);
                chk("busy_frame", busy_out, 1);
                chk("byte_done", byte_done_out, mon_cnt == BYTE_CYC - 1);
                chk("word_done", word_done_out, (mon_cnt == BYTE_CYC - 1) && cur.last);
                chk("ready_frame", word_ready_out, (mon_cnt == BYTE_CYC - 1) && cur.last);
                if (mon_cnt == BYTE_CYC - 1) begin
                    mon_active = 1'b0;
                    prev_end   = cyc;
                end else begin
                    mon_cnt++;
                end
            end else begin
                chk("idle_tx", tx_wire_out, 1);
                chk("idle_busy", busy_out, 0);
                chk("idle_ready", word_ready_out, 1);
                chk("idle_byte_done", byte_done_out, 0);
                chk("idle_word_done", word_done_out, 0);
            end
        end
    end

    task automatic send(input logic [15:0] w);
        @(negedge clk_in);
        word_in       = w;
        word_valid_in = 1'b1;
        chk("ready_before_accept", word_ready_out, 1);
        push_word(w, 1'b0);
        @(posedge clk_in);
        #1;
        word_valid_in = 1'b0;
        word_in       = 16'($urandom);
    endtask

    // Valid held across the word_done cycle: the second word must start with no idle cycle.
    task automatic send_b2b(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk_in);
        word_in       = a;
        word_valid_in = 1'b1;
        chk("ready_before_b2b", word_ready_out, 1);
        push_word(a, 1'b0);
        @(posedge clk_in);
        #1;
        word_in = b;
        push_word(b, 1'b1);
        repeat (2 * BYTE_CYC) @(posedge clk_in);
        #1;
        word_valid_in = 1'b0;
        word_in       = 16'($urandom);
    endtask

    task automatic ignored_pulse(input int at_cycle, input logic [15:0] w);
        repeat (at_cycle - 1) @(posedge clk_in);
        @(negedge clk_in);
        word_in       = w;
        word_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        word_valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || mon_active) && k < 600) begin
            @(posedge clk_in);
            #1;
            k++;
        end
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_frame", mon_active, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mode;
        rst_in        = 1'b0;
        word_in       = '0;
        word_valid_in = 1'b0;
        #2;
        rst_in = 1'b1;
        #2;
        chk("rst_tx", tx_wire_out, 1);
        chk("rst_busy", busy_out, 0);
        chk("rst_ready", word_ready_out, 1);
        chk("rst_byte_done", byte_done_out, 0);
        chk("rst_word_done", word_done_out, 0);
        word_valid_in = 1'b1;
        word_in       = 16'hBEEF;
        repeat (3) @(negedge clk_in);
        chk("rst_ignores_valid", word_ready_out, 1);
        word_valid_in = 1'b0;
        rst_in        = 1'b0;

        // Long idle: monitor checks line high, ready high, no strobes every cycle.
        repeat (100) @(posedge clk_in);
        send(16'h0000);
        wait_idle();

        send(16'hA55A);
        #1;
        chk("ready_drops", word_ready_out, 0);
        chk("busy_rises", busy_out, 1);
        chk("tx_low_after_accept", tx_wire_out, 0);
        wait_idle();

        send_b2b(16'h0001, 16'hFFFF);
        wait_idle();

        send(16'hC3E1);
        ignored_pulse(10, 16'h1234);
        wait_idle();

        // Reset 23 cycles into a frame: line high and busy low immediately, frame abandoned.
        send(16'h6B2D);
        repeat (22) @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_tx", tx_wire_out, 1);
        chk("midrst_busy", busy_out, 0);
        chk("midrst_ready", word_ready_out, 1);
        chk("midrst_word_done", word_done_out, 0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (5) @(posedge clk_in);
        send(16'h8E17);
        wait_idle();

        for (int i = 0; i < 12; i++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                send(16'($urandom));
            end else if (mode == 1) begin
                send_b2b(16'($urandom), 16'($urandom));
            end else begin
                send(16'($urandom));
                ignored_pulse(int'($urandom_range(2, 70)), 16'($urandom));
            end
            wait_idle();
            repeat ($urandom_range(0, 15)) @(posedge clk_in);
        end

        repeat (10) @(posedge clk_in);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
